// File: rtl/pkt_send_arb_pkg.sv
// rtl/pkt_send_arb_pkg.sv - shared constants, FSM state type and FIFO entry sizing
package pkt_send_arb_pkg;

  localparam int DATA_W  = 64;
  localparam int ROUTE_W = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } arb_state_e;

  function automatic int src_w(input int nbuf);
    return (nbuf > 1) ? $clog2(nbuf) : 1;
  endfunction

  // FIFO entry layout, MSB first: route, source index, bop, eop, data
  function automatic int entry_w(input int nbuf);
    return ROUTE_W + src_w(nbuf) + 2 + DATA_W;
  endfunction

endpackage

// File: rtl/pkt_send_arbiter_if.sv
// rtl/pkt_send_arbiter_if.sv - buffer-side send bus and TX-side stream of the send arbiter
interface pkt_send_arbiter_if #(parameter int NBUF = 4);
  import pkt_send_arb_pkg::*;

  localparam int SRC_W = src_w(NBUF);

  logic [NBUF-1:0]         buf_req;
  logic [NBUF-1:0]         buf_ack;
  logic [NBUF-1:0]         buf_rdy;
  logic [NBUF*DATA_W-1:0]  buf_data;
  logic [NBUF*ROUTE_W-1:0] buf_route;
  logic [NBUF-1:0]         buf_wr;
  logic [NBUF-1:0]         buf_bop;
  logic [NBUF-1:0]         buf_eop;

  logic [DATA_W-1:0]       tx_data;
  logic [ROUTE_W-1:0]      tx_route;
  logic [SRC_W-1:0]        tx_src;
  logic                    tx_wr;
  logic                    tx_bop;
  logic                    tx_eop;
  logic                    tx_rdy;

  modport master (
    output buf_req, buf_data, buf_route, buf_wr, buf_bop, buf_eop, tx_rdy,
    input  buf_ack, buf_rdy, tx_data, tx_route, tx_src, tx_wr, tx_bop, tx_eop
  );

  modport slave (
    input  buf_req, buf_data, buf_route, buf_wr, buf_bop, buf_eop, tx_rdy,
    output buf_ack, buf_rdy, tx_data, tx_route, tx_src, tx_wr, tx_bop, tx_eop
  );

endinterface

// File: rtl/pkt_send_fifo.sv
// rtl/pkt_send_fifo.sv - synchronous first-word-fall-through FIFO
module pkt_send_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Next pointers, occupancy and storage; simultaneous push and pop keep the count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only slots below count are ever read as valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pkt_send_arbiter.sv
// rtl/pkt_send_arbiter.sv - round-robin send arbiter feeding one TX stream; PKT_SEND_ARB_STATS_EN adds packet/word counters
module pkt_send_arbiter
  import pkt_send_arb_pkg::*;
#(
  parameter int NBUF       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  pkt_send_arbiter_if.slave  bus
`ifdef PKT_SEND_ARB_STATS_EN
  ,
  output logic [31:0]        stat_pkts,
  output logic [31:0]        stat_words
`endif
);

  localparam int SRC_W   = src_w(NBUF);
  localparam int ENTRY_W = entry_w(NBUF);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  arb_state_e        state_q, state_d;
  logic [SRC_W-1:0]  sel_q, sel_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NBUF-1:0]   ack_q, ack_d;
  logic [SRC_W-1:0]  pick, scan_idx;
  logic              pick_valid;

  logic              sel_req, sel_wr, sel_bop, sel_eop;
  logic [DATA_W-1:0] sel_data;
  logic [ROUTE_W-1:0] sel_route;

  logic              grant_rdy, push, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0] push_entry, head;

  // First requester at or after rr_ptr, scanning upward with wrap
  always_comb begin
    pick       = rr_ptr_q;
    pick_valid = 1'b0;
    scan_idx   = '0;
    for (int i = 0; i < NBUF; i++) begin
      scan_idx = SRC_W'((int'(rr_ptr_q) + i) % NBUF);
      if (!pick_valid && bus.buf_req[scan_idx]) begin
        pick       = scan_idx;
        pick_valid = 1'b1;
      end
    end
  end

  // Route the granted buffer's signals onto the push path
  always_comb begin
    sel_req   = 1'b0;
    sel_wr    = 1'b0;
    sel_bop   = 1'b0;
    sel_eop   = 1'b0;
    sel_data  = '0;
    sel_route = '0;
    for (int i = 0; i < NBUF; i++) begin
      if (sel_q == SRC_W'(i)) begin
        sel_req   = bus.buf_req[i];
        sel_wr    = bus.buf_wr[i];
        sel_bop   = bus.buf_bop[i];
        sel_eop   = bus.buf_eop[i];
        sel_data  = bus.buf_data[i*DATA_W +: DATA_W];
        sel_route = bus.buf_route[i*ROUTE_W +: ROUTE_W];
      end
    end
  end

  assign grant_rdy   = (state_q == GRANT) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign bus.buf_ack = ack_q;
  assign bus.buf_rdy = grant_rdy ? ack_q : '0;
  assign push        = grant_rdy && sel_wr && !fifo_full;
  assign push_entry  = {sel_route, sel_q, sel_bop, sel_eop, sel_data};
  assign pop         = bus.tx_rdy && !fifo_empty;

  // Arbitration FSM next state; the pointer advances past the winner on release
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_d   = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!sel_req) state_d = RELEASE;
      end
      RELEASE: begin
        rr_ptr_d = (sel_q == SRC_W'(NBUF-1)) ? '0 : sel_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ack_d = '0;
    if (state_d == GRANT) ack_d[sel_d] = 1'b1;
  end

  // FSM and registered ack; reset drops any grant immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
    end
  end

  pkt_send_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.tx_data  = head[DATA_W-1:0];
  assign bus.tx_eop   = head[DATA_W];
  assign bus.tx_bop   = head[DATA_W+1];
  assign bus.tx_src   = head[DATA_W+2 +: SRC_W];
  assign bus.tx_route = head[DATA_W+2+SRC_W +: ROUTE_W];
  assign bus.tx_wr    = pop;

`ifdef PKT_SEND_ARB_STATS_EN
  logic [31:0] stat_pkts_q, stat_pkts_d;
  logic [31:0] stat_words_q, stat_words_d;

  // Count delivered words and packet ends, wrapping naturally
  always_comb begin
    stat_pkts_d  = stat_pkts_q;
    stat_words_d = stat_words_q;
    if (pop) begin
      stat_words_d = stat_words_q + 32'd1;
      if (bus.tx_eop) stat_pkts_d = stat_pkts_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pkts_q  <= '0;
      stat_words_q <= '0;
    end else begin
      stat_pkts_q  <= stat_pkts_d;
      stat_words_q <= stat_words_d;
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_words = stat_words_q;
`endif

endmodule

// File: tb/tb_pkt_send_arbiter.sv
// tb/tb_pkt_send_arbiter.sv - randomized self-checking bench for pkt_send_arbiter
module tb_pkt_send_arbiter;
  import pkt_send_arb_pkg::*;

  localparam int NBUF  = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] data;
    logic [23:0] route;
    int          src;
    logic        bop;
    logic        eop;
  } word_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pkt_send_arbiter_if #(.NBUF(NBUF)) bus();

`ifdef PKT_SEND_ARB_STATS_EN
  logic [31:0] stat_pkts, stat_words;
`endif

  pkt_send_arbiter #(.NBUF(NBUF), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave)
`ifdef PKT_SEND_ARB_STATS_EN
    ,
    .stat_pkts  (stat_pkts),
    .stat_words (stat_words)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  word_t       exp_q[$];
  int          left[NBUF];
  int          pos[NBUF];
  int          gap[NBUF];
  bit          active[NBUF];
  logic [23:0] rt[NBUF];
  int          rr_m;
  logic [NBUF-1:0] prev_ack, req_prev;
  int          m_pkts, m_words;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NBUF-1:0] r, input int p);
    for (int k = 0; k < NBUF; k++)
      if (r[(p + k) % NBUF]) return (p + k) % NBUF;
    return -1;
  endfunction

  task automatic clear_inputs();
    bus.buf_req   = '0;
    bus.buf_wr    = '0;
    bus.buf_bop   = '0;
    bus.buf_eop   = '0;
    bus.buf_data  = '0;
    bus.buf_route = '0;
    bus.tx_rdy    = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int b = 0; b < NBUF; b++) begin
      active[b] = 0; left[b] = 0; pos[b] = 0; gap[b] = 0;
    end
    rr_m = 0; prev_ack = '0; req_prev = '0; m_pkts = 0; m_words = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    bus.tx_rdy = 1'b1;
    #1;
    chk("rst_ack", bus.buf_ack, '0);
    chk("rst_rdy", bus.buf_rdy, '0);
    chk("rst_tx_wr", bus.tx_wr, 1'b0);
    model_reset();
  endtask

  task automatic step(input int pct, input bit allow_new);
    logic [NBUF-1:0] ack, rdy;
    int    w, sb;
    bit    have, trdy;
    word_t nw, e;
    @(negedge clk);
    ack = bus.buf_ack;
    rdy = bus.buf_rdy;
    chk("ack_onehot", $onehot0(ack), 1'b1);
    if (ack != '0 && prev_ack == '0) begin
      w = rr_pick(req_prev, rr_m);
      chk("grant", ack, (w >= 0) ? (128'd1 << w) : 128'd0);
      if (w >= 0) rr_m = (w + 1) % NBUF;
    end
    prev_ack = ack;
    for (int b = 0; b < NBUF; b++)
      chk("rdy", rdy[b], ack[b] && (exp_q.size() < DEPTH));
    bus.buf_wr = '0; bus.buf_bop = '0; bus.buf_eop = '0;
    have = 0;
    for (int b = 0; b < NBUF; b++) begin
      if (active[b] && ack[b]) begin
        if (left[b] == 0) begin
          bus.buf_req[b] = 1'b0; active[b] = 0; gap[b] = $urandom_range(3);
        end else if (rdy[b] && $urandom_range(3) != 0) begin
          nw.data = {$urandom(), $urandom()}; nw.route = rt[b]; nw.src = b;
          nw.bop = (pos[b] == 0); nw.eop = (left[b] == 1);
          bus.buf_wr[b] = 1'b1; bus.buf_bop[b] = nw.bop; bus.buf_eop[b] = nw.eop;
          bus.buf_data[b*64 +: 64] = nw.data;
          pos[b]++; left[b]--; have = 1;
        end else if (!rdy[b] && $urandom_range(1) == 0) begin
          bus.buf_wr[b] = 1'b1; bus.buf_data[b*64 +: 64] = {$urandom(), $urandom()};
        end
      end else if (!active[b]) begin
        if (gap[b] > 0) gap[b]--;
        else if (allow_new && $urandom_range(2) == 0) begin
          active[b] = 1; bus.buf_req[b] = 1'b1; left[b] = $urandom_range(6, 1); pos[b] = 0;
          rt[b] = 24'($urandom()); bus.buf_route[b*24 +: 24] = rt[b];
        end
      end
    end
    if ($urandom_range(4) == 0) begin
      sb = $urandom_range(NBUF - 1);
      if (!ack[sb] && !bus.buf_wr[sb]) begin
        bus.buf_wr[sb] = 1'b1; bus.buf_bop[sb] = 1'b1; bus.buf_eop[sb] = 1'b1;
        bus.buf_data[sb*64 +: 64] = {$urandom(), $urandom()};
      end
    end
    trdy = ($urandom_range(99) < pct);
    bus.tx_rdy = trdy;
    #1;
    chk("tx_wr", bus.tx_wr, trdy && (exp_q.size() > 0));
    if (trdy && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tx_data", bus.tx_data, e.data);
      chk("tx_route", bus.tx_route, e.route);
      chk("tx_src", bus.tx_src, e.src);
      chk("tx_flags", {bus.tx_bop, bus.tx_eop}, {e.bop, e.eop});
      m_words++;
      if (e.eop) m_pkts++;
    end
    if (have) exp_q.push_back(nw);
    req_prev = bus.buf_req;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    clear_inputs();
    model_reset();
    do_reset();

    // single buffer 0, three words A/B/C
    @(negedge clk);
    bus.buf_req[0] = 1'b1; bus.buf_route[23:0] = 24'h000123; bus.tx_rdy = 1'b1;
    #1 chk("d_ack_t", bus.buf_ack, 4'b0000);
    @(negedge clk);
    chk("d_ack_t1", bus.buf_ack, 4'b0001);
    chk("d_rdy_t1", bus.buf_rdy, 4'b0001);
    bus.buf_wr[0] = 1'b1; bus.buf_bop[0] = 1'b1; bus.buf_data[63:0] = 64'hAAAA_0000_0000_000A;
    @(negedge clk);
    bus.buf_bop[0] = 1'b0; bus.buf_data[63:0] = 64'hBBBB_0000_0000_000B;
    #1;
    chk("d_a_wr", bus.tx_wr, 1'b1);
    chk("d_a_data", bus.tx_data, 64'hAAAA_0000_0000_000A);
    chk("d_a_flags", {bus.tx_bop, bus.tx_eop}, 2'b10);
    chk("d_a_route", bus.tx_route, 24'h000123);
    chk("d_a_src", bus.tx_src, 2'd0);
    @(negedge clk);
    bus.buf_eop[0] = 1'b1; bus.buf_data[63:0] = 64'hCCCC_0000_0000_000C;
    #1;
    chk("d_b_data", bus.tx_data, 64'hBBBB_0000_0000_000B);
    chk("d_b_flags", {bus.tx_bop, bus.tx_eop}, 2'b00);
    @(negedge clk);
    bus.buf_wr[0] = 1'b0; bus.buf_eop[0] = 1'b0; bus.buf_req[0] = 1'b0;
    #1;
    chk("d_c_data", bus.tx_data, 64'hCCCC_0000_0000_000C);
    chk("d_c_flags", {bus.tx_bop, bus.tx_eop}, 2'b01);
    chk("d_ack_fall", bus.buf_ack, 4'b0001);
    @(negedge clk);
    #1;
    chk("d_ack_release", bus.buf_ack, 4'b0000);
    chk("d_empty", bus.tx_wr, 1'b0);
    @(negedge clk);
    chk("d_ack_idle", bus.buf_ack, 4'b0000);
    bus.buf_req[0] = 1'b1;
    @(negedge clk);
    chk("d_ack_regrant", bus.buf_ack, 4'b0001);
    bus.buf_req[0] = 1'b0;
    do_reset();

    // buffers 1 and 3 together, then buffer 1 again
    @(negedge clk);
    bus.buf_req = 4'b1010;
    @(negedge clk);
    chk("rr_first", bus.buf_ack, 4'b0010);
    bus.buf_req[1] = 1'b0;
    @(negedge clk);
    chk("rr_release", bus.buf_ack, 4'b0000);
    bus.buf_req[1] = 1'b1;
    @(negedge clk);
    chk("rr_idle", bus.buf_ack, 4'b0000);
    @(negedge clk);
    chk("rr_second", bus.buf_ack, 4'b1000);
    bus.buf_req[3] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rr_third", bus.buf_ack, 4'b0010);
    bus.buf_req = '0;
    do_reset();

    // random traffic, busy downstream
    for (int k = 0; k < 2500; k++) step(70, 1'b1);

    // reset in the middle of a packet with data queued
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      step(20, 1'b1);
      if (bus.buf_ack != '0 && exp_q.size() > 0) found = 1;
    end
    chk("mid_pkt_found", found, 1'b1);
    do_reset();

    // random traffic, mostly stalled downstream, then drain
    for (int k = 0; k < 2000; k++) step(25, 1'b1);
    for (int k = 0; k < 300; k++) step(100, 1'b0);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", bus.buf_req, '0);
`ifdef PKT_SEND_ARB_STATS_EN
    chk("stat_pkts", stat_pkts, m_pkts);
    chk("stat_words", stat_words, m_words);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
